fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Write-side arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write-clock domain. Grants are round-robin, held for one burst (terminated by `last` or by MAXBURST words), and every word is flow-controlled by the FIFO's `wfull`. Sits directly in front of the FIFO's `winc`/`wdata` inputs; the read side is untouched.

## Interface
- DSIZE, 32, data word width; equals the FIFO's DSIZE.
- NREQ, 4, number of requesters, 2..16.
- MAXBURST, 16, maximum words per grant before forced rotation, >= 1.
- wclk  in  1  write-domain clock; all logic on rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester word-valid; requester holds it plus data until acked.
- req_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  marks the final word of requester i's burst.
- ack  out  NREQ  one-hot; word accepted this cycle.
- wfull  in  1  FIFO full flag, wclk domain.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data.
- gnt_id  out  $clog2(NREQ)  index of the current or last grantee.
- busy  out  1  grant held (state GRANT).
- word_cnt  out  NREQ*16  per-requester accepted-word counters (only with WR_ARB_CNT_EN).
- cnt_clr  in  1  synchronous clear of all word_cnt (only with WR_ARB_CNT_EN).

## Operation
- States: IDLE, GRANT.
- IDLE: if any req, select the first asserted requester searching upward from rr_ptr with wrap at NREQ-1 -> 0; register gnt_id, clear burst counter, go to GRANT. No req: stay.
- GRANT: ack[gnt_id] = req[gnt_id] & ~wfull; winc = |ack; wdata = req_data slice of gnt_id (driven whenever busy, don't-care when winc=0).
- Each accepted word increments the burst counter, width $clog2(MAXBURST+1).
- Release to IDLE, with rr_ptr = (gnt_id+1) mod NREQ, when any holds:
  - accepted word has req_last=1;
  - accepted word brings the burst counter to MAXBURST;
  - req[gnt_id]=0 in GRANT (abandoned burst, no transfer).
- wfull=1 in GRANT: no ack, no winc, counter frozen, grant held indefinitely.
- Requests from non-granted requesters are ignored until the next IDLE.
- Single active requester: re-granted after the one-cycle IDLE bubble.
- MAXBURST=1: rotation after every word.

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt_id 0, busy 0, ack 0, winc 0, burst counter 0, word_cnt 0.
- Arbitration latency: req rises at edge n while in IDLE -> busy=1 and ack possible in cycle n+1.
- ack/winc are combinational from wfull and req in GRANT (wfull is a registered FIFO flag); no further combinational paths.
- Burst release: the last word accepted in cycle m -> IDLE in m+1, next grant in m+2. Sustained rate is MAXBURST words per MAXBURST+1 cycles.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronous). The partial burst is lost from the arbiter's view; the FIFO keeps the words already written.

## Configuration
- WR_ARB_CNT_EN defined: word_cnt and cnt_clr exist.
  - Counter i increments on ack[i] and saturates at 16'hFFFF.
  - cnt_clr wins over a simultaneous increment.
- Undefined: both ports are absent and no counter logic is built; arbitration is identical.

## Structure
- Package fifo_wr_arb_pkg: state enum (IDLE, GRANT), constant CNT_W=16.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid and index.
  - Instantiated once.

## Test plan
- Reset, then req=4'b0001 with 3 words, last on the 3rd, wfull=0 -> gnt_id=0; ack on cycles 1-3; winc carries the 3 words in order; busy drops in cycle 4.
- req=4'b1111 held, every word last, MAXBURST=16 -> grant order 0,1,2,3,0; one IDLE cycle between grants.
- Requester 2 streams 20 words with no last, MAXBURST=16 -> 16 acks, release, requester 3 granted if requesting, else requester 2 re-granted after the bubble.
- wfull=1 for 5 cycles mid-burst -> winc=0 and ack=0 for exactly those cycles; grant and burst count held; burst completes afterwards with no word lost or duplicated.
- Grantee drops req mid-burst -> no transfer that cycle; IDLE next cycle; rr_ptr advances past it.
- WR_ARB_CNT_EN: 70000 words from requester 1 -> word_cnt[1]=16'hFFFF. cnt_clr on the same cycle as an ack -> counter reads 0 next cycle. wrst_n pulsed mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - requester/FIFO write-side bundle; master drives requests and wfull, slave is the arbiter
interface fifo_wr_arb_if #(
    parameter int DSIZE = 32,
    parameter int NREQ  = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       ack;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         gnt_id;
    logic                  busy;

    modport master (
        output req, req_data, req_last, wfull,
        input  ack, winc, wdata, gnt_id, busy
    );

    modport slave (
        input  req, req_data, req_last, wfull,
        output ack, winc, wdata, gnt_id, busy
    );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - combinational round-robin pick: first set req at or above ptr, wrapping
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from farthest to nearest so the closest request to ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr) + k) % NREQ)]) begin
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter for the async FIFO write port; WR_ARB_CNT_EN adds per-requester word counters
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int DSIZE    = 32,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    fifo_wr_arb_if.slave          bus
`ifdef WR_ARB_CNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [NREQ*CNT_W-1:0] word_cnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST + 1);

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n;
    logic [IW-1:0] gnt_id, gnt_id_n;
    logic [BW-1:0] bcnt, bcnt_n, bcnt_inc;
    logic [IW-1:0] gnt_next;
    logic [NREQ-1:0] ack;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign bcnt_inc = bcnt + 1'b1;
    assign gnt_next = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
            bcnt   <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            gnt_id <= gnt_id_n;
            bcnt   <= bcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        gnt_id_n = gnt_id;
        bcnt_n   = bcnt;
        ack      = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_id_n = pick_idx;
                    bcnt_n   = '0;
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[gnt_id]) begin
                    // Grantee abandoned its burst: give the port up without a transfer.
                    state_n  = IDLE;
                    rr_ptr_n = gnt_next;
                end else if (!bus.wfull) begin
                    ack[gnt_id] = 1'b1;
                    bcnt_n      = bcnt_inc;
                    if (bus.req_last[gnt_id] || bcnt_inc == BW'(MAXBURST)) begin
                        state_n  = IDLE;
                        rr_ptr_n = gnt_next;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ack    = ack;
    assign bus.winc   = |ack;
    assign bus.wdata  = bus.req_data[int'(gnt_id)*DSIZE +: DSIZE];
    assign bus.gnt_id = gnt_id;
    assign bus.busy   = (state == GRANT);

`ifdef WR_ARB_CNT_EN
    logic [CNT_W-1:0] cnt [NREQ];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (ack[i] && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        word_cnt = '0;
        for (int i = 0; i < NREQ; i++) word_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;

    localparam int DSIZE    = 32;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 16;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    fifo_wr_arb_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

`ifdef WR_ARB_CNT_EN
    logic              cnt_clr;
    logic [NREQ*16-1:0] word_cnt;
`endif

    fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
`ifdef WR_ARB_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .word_cnt (word_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic mid();
        @(negedge wclk);
    endtask

    task automatic do_reset();
        wrst_n       = 1'b0;
        bus.req      = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.wfull    = 1'b0;
`ifdef WR_ARB_CNT_EN
        cnt_clr      = 1'b0;
`endif
        tick();
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n       = 1'b0;
        bus.req      = 4'b1111;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.wfull    = 1'b0;
`ifdef WR_ARB_CNT_EN
        cnt_clr      = 1'b0;
`endif
        tick();
        mid();
        total++;
        if (bus.busy !== 1'b0 || bus.winc !== 1'b0 || bus.ack !== 4'b0000 || bus.gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL reset busy=%b winc=%b ack=%b gnt=%0d want 0/0/0000/0",
                     bus.busy, bus.winc, bus.ack, bus.gnt_id);
        end
    endtask

    task automatic test_single();
        int w = 0;
        logic [3:0] ea;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            bus.req[0]          = (w < 3);
            bus.req_last[0]     = (w == 2);
            bus.req_data[0 +: DSIZE] = 32'h100 + w;
            mid();
            ea = (c >= 1 && c <= 3) ? 4'b0001 : 4'b0000;
            total++;
            if (bus.ack !== ea || bus.winc !== ea[0] || bus.busy !== ea[0] ||
                (ea[0] && (bus.wdata !== 32'h100 + c - 1 || bus.gnt_id !== 2'd0))) begin
                bad++;
                $display("FAIL single c=%0d ack=%b busy=%b wdata=%h gnt=%0d want ack=%b wdata=%h",
                         c, bus.ack, bus.busy, bus.wdata, bus.gnt_id, ea, 32'h100 + c - 1);
            end
            if (bus.ack[0]) w++;
            tick();
        end
        bus.req = '0;
    endtask

    task automatic test_rotate();
        int g;
        logic [3:0] ea;
        do_reset();
        bus.req      = 4'b1111;
        bus.req_last = 4'b1111;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DSIZE +: DSIZE] = 32'hA0 + i;
        for (int c = 0; c <= 9; c++) begin
            mid();
            g  = (c / 2) % 4;
            ea = (c % 2 == 1) ? 4'(1 << g) : 4'b0000;
            total++;
            if (bus.ack !== ea || bus.busy !== (c % 2 == 1) ||
                ((c % 2 == 1) && (bus.gnt_id !== 2'(g) || bus.wdata !== 32'hA0 + g))) begin
                bad++;
                $display("FAIL rotate c=%0d ack=%b gnt=%0d wdata=%h want ack=%b gnt=%0d",
                         c, bus.ack, bus.gnt_id, bus.wdata, ea, g);
            end
            tick();
        end
        bus.req = '0;
    endtask

    task automatic test_maxburst();
        int w = 0;
        logic [3:0]  ea;
        logic [31:0] ed;
        int eg;
        do_reset();
        bus.req      = 4'b1100;
        bus.req_last = 4'b1000;
        bus.req_data[3*DSIZE +: DSIZE] = 32'h3C3C;
        for (int c = 0; c <= 20; c++) begin
            bus.req_data[2*DSIZE +: DSIZE] = 32'h200 + w;
            mid();
            eg = 2;
            ed = 32'h200 + ((c <= 16) ? c - 1 : 16);
            if (c == 0 || c == 17 || c == 19) ea = 4'b0000;
            else if (c == 18) begin ea = 4'b1000; eg = 3; ed = 32'h3C3C; end
            else ea = 4'b0100;
            total++;
            if (bus.ack !== ea || (ea != 0 && (bus.gnt_id !== 2'(eg) || bus.wdata !== ed))) begin
                bad++;
                $display("FAIL maxburst c=%0d ack=%b gnt=%0d wdata=%h want ack=%b gnt=%0d wdata=%h",
                         c, bus.ack, bus.gnt_id, bus.wdata, ea, eg, ed);
            end
            if (bus.ack[2]) w++;
            tick();
        end
        bus.req = '0;
    endtask

    task automatic test_wfull();
        int w = 0;
        logic ea;
        logic eb;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            bus.req[0]               = (w < 8);
            bus.req_last[0]          = (w == 7);
            bus.req_data[0 +: DSIZE] = 32'h300 + w;
            bus.wfull                = (c >= 4 && c <= 8);
            mid();
            ea = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
            eb = (c >= 1 && c <= 13);
            total++;
            if (bus.ack !== {3'b000, ea} || bus.winc !== ea || bus.busy !== eb ||
                (ea && bus.wdata !== 32'h300 + ((c <= 3) ? c - 1 : c - 6))) begin
                bad++;
                $display("FAIL wfull c=%0d ack=%b winc=%b busy=%b wdata=%h want ack=%b busy=%b",
                         c, bus.ack, bus.winc, bus.busy, bus.wdata, ea, eb);
            end
            if (bus.ack[0]) w++;
            tick();
        end
        total++;
        if (w !== 8) begin
            bad++;
            $display("FAIL wfull_words got=%0d want=8", w);
        end
        bus.wfull = 1'b0;
        bus.req   = '0;
    endtask

    task automatic test_drop();
        logic [3:0] ea;
        do_reset();
        bus.req_last = 4'b0010;
        bus.req_data[0 +: DSIZE]     = 32'h400;
        bus.req_data[DSIZE +: DSIZE] = 32'h500;
        for (int c = 0; c <= 4; c++) begin
            bus.req = {2'b00, 1'b1, (c < 2)};
            mid();
            ea = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
            total++;
            if (bus.ack !== ea || bus.winc !== (ea != 0) ||
                bus.busy !== (c == 1 || c == 2 || c == 4) ||
                (c == 4 && (bus.gnt_id !== 2'd1 || bus.wdata !== 32'h500))) begin
                bad++;
                $display("FAIL drop c=%0d ack=%b winc=%b busy=%b gnt=%0d want ack=%b",
                         c, bus.ack, bus.winc, bus.busy, bus.gnt_id, ea);
            end
            tick();
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req      = 4'b0100;
        bus.req_last = '0;
        tick();
        mid();
        total++;
        if (bus.busy !== 1'b1 || bus.gnt_id !== 2'd2 || bus.ack !== 4'b0100) begin
            bad++;
            $display("FAIL rstmid_pre busy=%b gnt=%0d ack=%b want 1/2/0100",
                     bus.busy, bus.gnt_id, bus.ack);
        end
        wrst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.gnt_id !== 2'd0 || bus.ack !== 4'b0000 || bus.winc !== 1'b0) begin
            bad++;
            $display("FAIL rstmid busy=%b gnt=%0d ack=%b winc=%b want all 0",
                     bus.busy, bus.gnt_id, bus.ack, bus.winc);
        end
        tick();
        bus.req = '0;
        wrst_n  = 1'b1;
    endtask

`ifdef WR_ARB_CNT_EN
    task automatic test_cnt();
        int n   = 0;
        int cyc = 0;
        bit hit = 0;
        do_reset();
        bus.req      = 4'b0010;
        bus.req_last = '0;
        while (n < 70000 && cyc < 80000) begin
            mid();
            if (bus.ack[1]) n++;
            tick();
            cyc++;
        end
        bus.req = '0;
        mid();
        total++;
        if (n !== 70000 || word_cnt[16 +: 16] !== 16'hFFFF || word_cnt[0 +: 16] !== 16'h0) begin
            bad++;
            $display("FAIL cnt_sat acks=%0d cnt1=%h cnt0=%h want 70000/ffff/0000",
                     n, word_cnt[16 +: 16], word_cnt[0 +: 16]);
        end
        tick();
        bus.req = 4'b0010;
        for (int c = 0; c < 10 && !hit; c++) begin
            mid();
            if (bus.ack[1]) begin
                hit     = 1;
                cnt_clr = 1'b1;
                tick();
                cnt_clr = 1'b0;
                mid();
                total++;
                if (word_cnt[16 +: 16] !== 16'h0) begin
                    bad++;
                    $display("FAIL cnt_clr cnt1=%h want 0000", word_cnt[16 +: 16]);
                end
            end
            tick();
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL cnt_clr_timeout no ack within 10 cycles");
        end
        bus.req = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_maxburst();
        test_wfull();
        test_drop();
        test_reset_mid();
`ifdef WR_ARB_CNT_EN
        test_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
